cpu_mc: RTL

Parametrised multi-cycle successor to the single-cycle 8-bit CPU core: configurable data width and register count, with jump/branch instructions and a data-memory port governed by a busy-wait handshake. It sits between the instruction memory, which is combinationally indexed by PC, and the data memory or cache, which responds over MEM_*. The core stalls the program counter for as long as a memory access is outstanding.

---
 rtl/cpu_mc_pkg.sv | 47 ++++
 rtl/cpu_mc_reg_file_p.sv | 44 ++++
 rtl/cpu_mc.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_mc_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mc_pkg
// Shared opcodes, FSM state type and instruction field positions for cpu_mc.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_mc_pkg;

    // Opcode encodings; anything not listed here executes as a NOP
    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;
    localparam logic [7:0] OP_LWD   = 8'd8;
    localparam logic [7:0] OP_LWI   = 8'd9;
    localparam logic [7:0] OP_SWD   = 8'd10;
    localparam logic [7:0] OP_SWI   = 8'd11;

    // Instruction field bit positions
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 24;
    localparam int DST_HI  = 23;
    localparam int DST_LO  = 16;
    localparam int SRC1_HI = 15;
    localparam int SRC1_LO = 8;
    localparam int SRC2_HI = 7;
    localparam int SRC2_LO = 0;

    // Core control state: executing, or waiting on a data-memory access
    typedef enum logic [0:0] {
        EXEC = 1'b0,
        MEM  = 1'b1
    } state_e;

    // True for the four data-memory opcodes
    function automatic logic is_mem_op(input logic [7:0] op);
        return (op == OP_LWD) || (op == OP_LWI) || (op == OP_SWD) || (op == OP_SWI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_mc_reg_file_p.sv
// ---------------------------------------------------------------------------
// reg_file_p
// Parametrised register file: two combinational read ports, one write port
// clocked on the rising edge, asynchronous active-low clear.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module reg_file_p #(
    parameter  int DATA_W = 8,
    parameter  int NREGS  = 8,
    localparam int AW     = ($clog2(NREGS) > 0) ? $clog2(NREGS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [AW-1:0]     raddr2_i,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] regs_q [NREGS];

    // Storage: cleared asynchronously, written at the rising edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-edge value, so a same-cycle write is not forwarded
    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];

endmodule

`default_nettype wire

// File: rtl/cpu_mc.sv
// ---------------------------------------------------------------------------
// cpu_mc
// Multi-cycle CPU core: single-cycle ALU/branch instructions, two-state
// EXEC/MEM sequencing for loads and stores with busy-wait stalling.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       INSTRUCTION,
    output logic [31:0]       PC,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_BUSYWAIT
);

    localparam int RA_W = ($clog2(NREGS) > 0) ? $clog2(NREGS) : 1;

    // Instruction fields
    logic [7:0] op;
    logic [7:0] dst_f;
    logic [7:0] src1_f;
    logic [7:0] src2_f;

    assign op     = INSTRUCTION[OPC_HI:OPC_LO];
    assign dst_f  = INSTRUCTION[DST_HI:DST_LO];
    assign src1_f = INSTRUCTION[SRC1_HI:SRC1_LO];
    assign src2_f = INSTRUCTION[SRC2_HI:SRC2_LO];

    // Only the low RA_W bits of src1 select a register
    logic unused_src1;
    assign unused_src1 = ^src1_f;

    // Sequential state
    state_e            state_q;
    logic [31:0]       pc_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [RA_W-1:0]   ld_dst_q;

    // Decode
    logic is_mem;
    logic is_load;
    logic is_store;
    logic is_direct;

    assign is_mem    = is_mem_op(op);
    assign is_load   = (op == OP_LWD) || (op == OP_LWI);
    assign is_store  = (op == OP_SWD) || (op == OP_SWI);
    assign is_direct = (op == OP_LWD) || (op == OP_SWD);

    // Register file hookup; port 1 reads the dest field for stores (store data)
    logic [RA_W-1:0]   rd1_addr;
    logic [RA_W-1:0]   rd2_addr;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic              wr_en;
    logic [RA_W-1:0]   wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign rd1_addr = is_store ? dst_f[RA_W-1:0] : src1_f[RA_W-1:0];
    assign rd2_addr = src2_f[RA_W-1:0];

    reg_file_p #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regs (
        .clk_i    (CLK),
        .rst_ni   (RESET),
        .we_i     (wr_en),
        .waddr_i  (wr_addr),
        .wdata_i  (wr_data),
        .raddr1_i (rd1_addr),
        .rdata1_o (rd1_data),
        .raddr2_i (rd2_addr),
        .rdata2_o (rd2_data)
    );

    // Sign-extended immediate and the data-memory address for this instruction
    logic [DATA_W-1:0] imm_sext;
    logic [ADDR_W-1:0] mem_addr_d;

    assign imm_sext   = DATA_W'($signed(src2_f));
    assign mem_addr_d = is_direct ? ADDR_W'(rd2_data) : ADDR_W'(src2_f);

    // ALU: result and whether the opcode writes back at all
    logic [DATA_W-1:0] alu_res;
    logic              alu_we;

    always_comb begin
        alu_res = '0;
        alu_we  = 1'b1;
        case (op)
            OP_LOADI: alu_res = imm_sext;
            OP_MOV:   alu_res = rd2_data;
            OP_ADD:   alu_res = rd1_data + rd2_data;
            OP_SUB:   alu_res = rd1_data + ~rd2_data + DATA_W'(1);
            OP_AND:   alu_res = rd1_data & rd2_data;
            OP_OR:    alu_res = rd1_data | rd2_data;
            default:  alu_we  = 1'b0;
        endcase
    end

    // Next PC for non-memory instructions in EXEC
    logic [31:0] pc_inc;
    logic [31:0] br_tgt;
    logic [31:0] pc_d;

    assign pc_inc = pc_q + 32'd4;
    assign br_tgt = pc_inc + {{22{dst_f[7]}}, dst_f, 2'b00};

    always_comb begin
        pc_d = pc_inc;
        if (op == OP_J) begin
            pc_d = br_tgt;
        end else if ((op == OP_BEQ) && (rd1_data == rd2_data)) begin
            pc_d = br_tgt;
        end
    end

    // Write-back select: ALU result in EXEC, load data when the access completes
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = dst_f[RA_W-1:0];
        wr_data = alu_res;
        if (state_q == EXEC) begin
            wr_en = alu_we;
        end else if (!MEM_BUSYWAIT && mem_read_q) begin
            wr_en   = 1'b1;
            wr_addr = ld_dst_q;
            wr_data = MEM_RDATA;
        end
    end

    // Control FSM with registered PC and memory request outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= EXEC;
            pc_q        <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_dst_q    <= '0;
        end else begin
            case (state_q)
                EXEC: begin
                    if (is_mem) begin
                        state_q     <= MEM;
                        mem_read_q  <= is_load;
                        mem_write_q <= is_store;
                        mem_addr_q  <= mem_addr_d;
                        mem_wdata_q <= is_store ? rd1_data : '0;
                        ld_dst_q    <= dst_f[RA_W-1:0];
                    end else begin
                        pc_q <= pc_d;
                    end
                end
                MEM: begin
                    if (!MEM_BUSYWAIT) begin
                        state_q     <= EXEC;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        pc_q        <= pc_inc;
                    end
                end
                default: state_q <= EXEC;
            endcase
        end
    end

    assign PC        = pc_q;
    assign MEM_READ  = mem_read_q;
    assign MEM_WRITE = mem_write_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;

endmodule

`default_nettype wire
